instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage: the initiator side of the combinational instruction ROM interface. Holds the program counter, drives a word-aligned byte address to instruction memory every cycle and captures the returned 32-bit word with its PC into the IF/ID pipeline register. Handles stalls from hazard logic, branch redirects from the execute/branch unit, and out-of-range or misaligned fetches. Sits between instruction memory and the decode stage of the 64-bit ARM pipeline.

## Interface

Parameters:
- INSTRUCT_MEM_SIZE, 1024: instruction memory size in bytes; power of two, > 4.
- RESET_PC, 64'd0: PC loaded on reset; word-aligned.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID contents.
- br_taken  input  1  redirect request this cycle.
- br_target  input  64  redirect byte address.
- imem_addr  output  64  byte address to instruction memory; equals PC.
- imem_instr  input  32  combinational read data from instruction memory.
- if_pc  output  64  PC of the instruction in IF/ID.
- if_instr  output  32  instruction in IF/ID.
- if_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fault  output  1  sticky fetch-fault flag.

## Operation

- State machine, states RUN and FAULT. Reset enters RUN.
- Reset values:
  - PC = RESET_PC
  - if_pc = 0, if_instr = 0, if_valid = 0, fault = 0
- imem_addr = PC combinationally in all states.
- Per-posedge update priority: reset > FAULT hold > br_taken > stall > sequential.
- RUN, br_taken = 1:
  - If br_target is aligned (br_target[1:0] = 0) and br_target + 3 < INSTRUCT_MEM_SIZE: PC <= br_target, if_valid <= 0 (wrong-path word squashed).
  - Otherwise: go to FAULT, fault <= 1, if_valid <= 0, PC unchanged.
  - br_taken overrides stall.
- RUN, stall = 1, br_taken = 0: PC, if_pc, if_instr, if_valid all hold.
- RUN, sequential (no stall, no br_taken):
  - if_instr <= imem_instr, if_pc <= PC, if_valid <= 1.
  - If PC + 4 + 3 < INSTRUCT_MEM_SIZE: PC <= PC + 4.
  - Otherwise: the current word is still delivered valid; next state FAULT, fault <= 1, PC holds.
- FAULT: PC holds, if_valid <= 0, fault stays 1. Only reset exits; stall and br_taken are ignored.
- Arithmetic: PC + 4 is 64-bit unsigned. The bounds check uses 64-bit compare, so an address near 2^64 must not wrap into range; compare the address against INSTRUCT_MEM_SIZE - 4 rather than adding 3.
- If an X appears on br_target while br_taken = 0, it must not affect state.

## Timing

- Fetch latency: 1 cycle. The word at address PC in cycle N appears on if_instr/if_pc after posedge N+1.
- Branch penalty: 1 bubble. br_taken at cycle N gives if_valid = 0 after edge N+1; the target instruction is valid after edge N+2.
- Stall held k cycles freezes outputs for exactly k edges; no word is lost or duplicated.
- Reset asserted mid-stream: after that edge, outputs return to reset values and PC = RESET_PC, regardless of stall, branch or FAULT. The first valid instruction appears one edge after reset deasserts.
- fault asserts on the edge that enters FAULT and stays high until reset.

## Structure

- Shared package (cpu_pkg): INSTRUCT_MEM_SIZE default, fetch_state_t enum (RUN, FAULT), and an if_id_t struct {pc, instr, valid} reused by decode.
- One natural sub-module: pc_reg, a 64-bit enable/load register with synchronous reset to RESET_PC. The next-PC mux and FSM stay in instr_fetch.
- The bench instantiates the existing instruction ROM with a directed program file.

## Test plan

- Reset then free-run over words at 0x0, 0x4, 0x8 -> if_pc sequence 0, 4, 8 on consecutive edges, if_valid = 1 from the first edge after reset drops, if_instr matching ROM contents.
- stall held 3 cycles with PC = 0x10 -> if_pc stays 0xC and PC stays 0x10 for 3 edges; the next edge gives if_pc = 0x10.
- br_taken with br_target = 0x40 while PC = 0x8, stall also high -> one bubble (if_valid = 0), then if_pc = 0x40 valid.
- br_target = 0x42 (misaligned) or 0x400 (out of bounds, size 1024) -> fault = 1, if_valid = 0, PC frozen; later br_taken and stall have no effect.
- Sequential run to PC = 0x3FC -> word 0x3FC delivered valid, then fault = 1 and if_valid = 0 thereafter.
- reset pulsed while in FAULT and again mid-branch -> fault = 0, if_valid = 0, PC = RESET_PC after the edge; normal fetch resumes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the 64-bit ARM core: fetch FSM states, the IF/ID record
// and the instruction-memory bounds helper used by fetch.
package cpu_pkg;

    localparam int unsigned INSTRUCT_MEM_SIZE_DEF = 1024;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Word aligned and the whole word inside memory; the compare is done against
    // mem_size - 4 so an address near 2^64 cannot wrap back into range.
    function automatic logic fetch_addr_ok(input logic [63:0] addr,
                                           input logic [63:0] mem_size);
        return (addr[1:0] == 2'b00) && (addr <= (mem_size - 64'd4));
    endfunction

endpackage

// File: rtl/pc_reg.sv
// 64-bit program-counter register: synchronous reset to RESET_PC, load when enabled.
module pc_reg #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [63:0] i_d,
    output logic [63:0] o_q
);

    logic [63:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_en) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: drives PC to the combinational ROM, captures the word into
// IF/ID, and handles stall, branch redirect and sticky out-of-range/misaligned faults.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned INSTRUCT_MEM_SIZE = INSTRUCT_MEM_SIZE_DEF,
    parameter logic [63:0] RESET_PC          = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        fault
);

    localparam logic [63:0] MEM_SIZE = 64'(INSTRUCT_MEM_SIZE);

    fetch_state_t r_state;
    if_id_t       r_if_id;
    logic         r_fault;

    logic [63:0] w_pc;
    logic [63:0] w_pc_plus4;
    logic        w_br_ok;
    logic        w_seq_ok;
    logic        w_pc_en;
    logic [63:0] w_pc_d;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pc_en),
        .i_d   (w_pc_d),
        .o_q   (w_pc)
    );

    assign w_pc_plus4 = w_pc + 64'd4;
    assign w_br_ok    = fetch_addr_ok(br_target, MEM_SIZE);
    assign w_seq_ok   = fetch_addr_ok(w_pc_plus4, MEM_SIZE);

    // br_target is only looked at under br_taken so an undriven target cannot leak in.
    always_comb begin
        w_pc_en = 1'b0;
        w_pc_d  = w_pc;
        if (r_state == RUN) begin
            if (br_taken) begin
                if (w_br_ok) begin
                    w_pc_en = 1'b1;
                    w_pc_d  = br_target;
                end
            end else if (!stall) begin
                if (w_seq_ok) begin
                    w_pc_en = 1'b1;
                    w_pc_d  = w_pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_if_id <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (br_taken) begin
                        r_if_id.valid <= 1'b0;
                        if (!w_br_ok) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_if_id.instr <= imem_instr;
                        r_if_id.pc    <= w_pc;
                        r_if_id.valid <= 1'b1;
                        // Last in-range word still goes out valid; the fault covers the next.
                        if (!w_seq_ok) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    r_if_id.valid <= 1'b0;
                end
                default: begin
                    r_state       <= FAULT;
                    r_fault       <= 1'b1;
                    r_if_id.valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = w_pc;
    assign if_pc     = r_if_id.pc;
    assign if_instr  = r_if_id.instr;
    assign if_valid  = r_if_id.valid;
    assign fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised self-checking bench for instr_fetch against a cycle-level reference model
// fed from a ROM image held in the bench.
module tb_instr_fetch;

    localparam int unsigned MEM      = 1024;
    localparam logic [63:0] RPC      = 64'd0;
    localparam int unsigned AW       = $clog2(MEM);

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        fault;

    logic [31:0] rom [MEM/4];

    // Reference model state.
    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic        m_fault;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(
        .INSTRUCT_MEM_SIZE (MEM),
        .RESET_PC          (RPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid),
        .fault      (fault)
    );

    assign imem_instr = rom[imem_addr[AW-1:2]];

    always #5 clk = ~clk;

    // Rules: a word must lie wholly below MEM; 66-bit sums cannot wrap.
    task automatic model_edge();
        logic [65:0] last_byte;
        if (reset) begin
            m_pc       = RPC;
            m_if_pc    = '0;
            m_if_instr = '0;
            m_if_valid = 1'b0;
            m_fault    = 1'b0;
        end else if (m_fault) begin
            m_if_valid = 1'b0;
        end else if (br_taken) begin
            m_if_valid = 1'b0;
            last_byte  = {2'b00, br_target} + 66'd3;
            if (br_target[1:0] == 2'b00 && last_byte < 66'(MEM)) m_pc = br_target;
            else m_fault = 1'b1;
        end else if (!stall) begin
            m_if_instr = rom[int'(m_pc >> 2)];
            m_if_pc    = m_pc;
            m_if_valid = 1'b1;
            if ({2'b00, m_pc} + 66'd7 < 66'(MEM)) m_pc = m_pc + 64'd4;
            else m_fault = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 64'h8;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({imem_addr, if_pc, if_instr, if_valid, fault} !==
                {RPC, 64'd0, 32'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got addr=%h pc=%h instr=%h v=%b f=%b, want reset values",
                         i, imem_addr, if_pc, if_instr, if_valid, fault);
            end
        end
        stall = 1'b0; br_taken = 1'b0;
    endtask

    task automatic test_seq();
        do_reset();
        br_target = 'x;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({imem_addr, if_pc, if_instr, if_valid, fault} !==
                {m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault} ||
                if_pc !== 64'(4 * i) || if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq[%0d]: got addr=%h pc=%h instr=%h v=%b f=%b, want addr=%h pc=%h instr=%h v=1 f=%b",
                         i, imem_addr, if_pc, if_instr, if_valid, fault,
                         m_pc, 64'(4 * i), m_if_instr, m_fault);
            end
        end
        br_target = '0;
    endtask

    task automatic test_stall();
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_pc !== 64'hC || imem_addr !== 64'h10 || if_valid !== 1'b1 ||
                if_instr !== m_if_instr) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h addr=%h v=%b instr=%h, want pc=c addr=10 v=1 instr=%h",
                         i, if_pc, imem_addr, if_valid, if_instr, m_if_instr);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (if_pc !== 64'h10 || if_valid !== 1'b1 || if_instr !== rom[4]) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h v=%b instr=%h, want pc=10 v=1 instr=%h",
                     if_pc, if_valid, if_instr, rom[4]);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (2) tick();
        br_taken = 1'b1; br_target = 64'h40; stall = 1'b1;
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || imem_addr !== 64'h40 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_bubble: got v=%b addr=%h f=%b, want v=0 addr=40 f=0",
                     if_valid, imem_addr, fault);
        end
        br_taken = 1'b0; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({imem_addr, if_pc, if_instr, if_valid, fault} !==
                {m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault} ||
                if_pc !== 64'(64'h40 + 4 * i)) begin
                n_fail++;
                $display("FAIL branch_target[%0d]: got addr=%h pc=%h instr=%h v=%b f=%b, want addr=%h pc=%h instr=%h v=%b f=%b",
                         i, imem_addr, if_pc, if_instr, if_valid, fault,
                         m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault);
            end
        end
    endtask

    task automatic test_fault();
        logic [63:0] targets [3];
        targets[0] = 64'h42;
        targets[1] = 64'h400;
        targets[2] = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            repeat (2) tick();
            br_taken = 1'b1; br_target = targets[t];
            tick();
            n_checks++;
            if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'h8) begin
                n_fail++;
                $display("FAIL fault_entry[%0d]: got f=%b v=%b addr=%h, want f=1 v=0 addr=8",
                         t, fault, if_valid, imem_addr);
            end
            for (int i = 0; i < 4; i++) begin
                br_taken  = 1'($urandom_range(0, 1));
                stall     = 1'($urandom_range(0, 1));
                br_target = 64'h20;
                tick();
                n_checks++;
                if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'h8 ||
                    if_pc !== m_if_pc) begin
                    n_fail++;
                    $display("FAIL fault_hold[%0d.%0d]: got f=%b v=%b addr=%h pc=%h, want f=1 v=0 addr=8 pc=%h",
                             t, i, fault, if_valid, imem_addr, if_pc, m_if_pc);
                end
            end
            br_taken = 1'b0; stall = 1'b0;
        end
    endtask

    task automatic test_end_of_mem();
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            tick();
            n_checks++;
            if ({imem_addr, if_pc, if_instr, if_valid, fault} !==
                {m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault}) begin
                n_fail++;
                $display("FAIL end_run[%0d]: got addr=%h pc=%h instr=%h v=%b f=%b, want addr=%h pc=%h instr=%h v=%b f=%b",
                         i, imem_addr, if_pc, if_instr, if_valid, fault,
                         m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault);
            end
            if (i == 256) begin
                n_checks++;
                if (if_pc !== 64'h3FC || if_valid !== 1'b1 || fault !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last_word: got pc=%h v=%b f=%b, want pc=3fc v=1 f=1",
                             if_pc, if_valid, fault);
                end
            end
            if (i == 257) begin
                n_checks++;
                if (if_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 64'h3FC) begin
                    n_fail++;
                    $display("FAIL past_end: got v=%b f=%b addr=%h, want v=0 f=1 addr=3fc",
                             if_valid, fault, imem_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        br_taken = 1'b1; br_target = 64'h42;
        tick();
        reset = 1'b1; stall = 1'b1;
        tick();
        n_checks++;
        if ({imem_addr, if_valid, fault} !== {RPC, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_in_fault: got addr=%h v=%b f=%b, want addr=%h v=0 f=0",
                     imem_addr, if_valid, fault, RPC);
        end
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
        repeat (3) tick();
        br_taken = 1'b1; br_target = 64'h80;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({imem_addr, if_pc, if_valid, fault} !== {RPC, 64'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_branch: got addr=%h pc=%h v=%b f=%b, want addr=%h pc=0 v=0 f=0",
                     imem_addr, if_pc, if_valid, fault, RPC);
        end
        reset = 1'b0; br_taken = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_instr !== m_if_instr) begin
            n_fail++;
            $display("FAIL resume: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                     if_valid, if_pc, if_instr, RPC, m_if_instr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            stall    = ($urandom_range(0, 99) < 25);
            br_taken = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 9))
                0:       br_target = 64'($urandom_range(0, MEM - 1));
                1:       br_target = {$urandom, $urandom};
                default: br_target = 64'($urandom_range(0, MEM / 4 - 1)) << 2;
            endcase
            tick();
            n_checks++;
            if ({imem_addr, if_pc, if_instr, if_valid, fault} !==
                {m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault}) begin
                n_fail++;
                $display("FAIL random[%0d]: got addr=%h pc=%h instr=%h v=%b f=%b, want addr=%h pc=%h instr=%h v=%b f=%b",
                         i, imem_addr, if_pc, if_instr, if_valid, fault,
                         m_pc, m_if_pc, m_if_instr, m_if_valid, m_fault);
            end
        end
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MEM / 4; i++) rom[i] = $urandom;
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        m_pc = RPC; m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0; m_fault = 1'b0;
        #2;
        test_reset();
        test_seq();
        test_stall();
        test_branch();
        test_fault();
        test_end_of_mem();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
